// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO responder: FSM states, op encoding, default addresses.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ERR   = 2'd2
  } op_t;

  localparam logic [31:0] DEFAULT_LED_ADDRESS   = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_TIMER_ADDRESS = 32'h8000_0004;

  // Simultaneous read and write is an illegal request and is carried as its own op.
  function automatic op_t encode_op(input logic rd, input logic wr);
    op_t op;
    if (rd && wr) begin
      op = OP_ERR;
    end else if (wr) begin
      op = OP_WRITE;
    end else begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/mmio_ms_timer.sv
// Millisecond timer: prescaler divides clk down to 1 kHz, 32-bit ms counter wraps freely.
module mmio_ms_timer #(
  parameter int CLOCK_FREQ = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  output logic [31:0] count
);

  localparam int DIV = (CLOCK_FREQ / 1000 < 1) ? 1 : CLOCK_FREQ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] prescale_r;
  logic [31:0]   count_r;
  logic          tick_s;

  assign tick_s = (prescale_r == TERM);
  assign count  = count_r;

  // Prescaler and ms counter; a clear overrides a coincident tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale_r <= '0;
      count_r    <= 32'd0;
    end else if (clear) begin
      prescale_r <= '0;
      count_r    <= 32'd0;
    end else begin
      if (tick_s) begin
        prescale_r <= '0;
        count_r    <= count_r + 32'd1;
      end else begin
        prescale_r <= prescale_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Data-memory port target: word RAM, LED register and optional ms timer behind a ready handshake.
// Define MMIO_TIMER_EN to build the millisecond timer at TIMER_ADDRESS.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int          CLOCK_FREQ       = 25000000,
  parameter int          DATA_MEMORY_SIZE = 4096,
  parameter              MEMORY_FILE      = "",
  parameter logic [31:0] LED_ADDRESS      = DEFAULT_LED_ADDRESS,
  parameter logic [31:0] TIMER_ADDRESS    = DEFAULT_TIMER_ADDRESS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        bus_error,
  output logic [7:0]  leds
);

  localparam int          AW        = (DATA_MEMORY_SIZE > 1) ? $clog2(DATA_MEMORY_SIZE) : 1;
  localparam logic [29:0] RAM_WORDS = 30'(DATA_MEMORY_SIZE);

  logic [31:0] mem [DATA_MEMORY_SIZE];

  state_t        state_r, state_next_s;
  op_t           op_r;
  logic [31:0]   addr_r, wdata_r;
  logic          req_s, access_s;
  logic          ram_hit_s, led_hit_s, timer_hit_s, err_s, wr_ok_s, rd_ok_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   timer_count_s;
  logic [31:0]   ram_q_r, aux_data_r;
  logic          sel_ram_r, ready_r, bus_error_r;
  logic [7:0]    leds_r;

  assign req_s    = memory_read | memory_write;
  assign access_s = (state_r == ACCESS);

`ifdef MMIO_TIMER_EN
  logic timer_clear_s;
  assign timer_hit_s   = (addr_r == TIMER_ADDRESS);
  assign timer_clear_s = wr_ok_s && timer_hit_s;

  mmio_ms_timer #(.CLOCK_FREQ(CLOCK_FREQ)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear_s),
    .count (timer_count_s)
  );
`else
  assign timer_hit_s   = 1'b0;
  assign timer_count_s = 32'd0;
`endif

  // Address decode on the latched request; every error class collapses into err_s.
  always_comb begin
    ram_hit_s = (addr_r[31:2] < RAM_WORDS);
    led_hit_s = (addr_r == LED_ADDRESS);
    ram_idx_s = addr_r[AW+1:2];
    err_s     = (op_r == OP_ERR) || (addr_r[1:0] != 2'b00) ||
                !(ram_hit_s || led_hit_s || timer_hit_s);
    wr_ok_s   = access_s && (op_r == OP_WRITE) && !err_s;
    rd_ok_s   = access_s && (op_r == OP_READ) && !err_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: requests are only looked at in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Capture the request so later changes on the bus cannot disturb it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r    <= OP_READ;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if ((state_r == IDLE) && req_s) begin
      op_r    <= encode_op(memory_read, memory_write);
      addr_r  <= address;
      wdata_r <= write_data;
    end
  end

  // Word RAM, synchronous read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && wr_ok_s && ram_hit_s) begin
      mem[ram_idx_s] <= wdata_r;
    end
    if (access_s) begin
      ram_q_r <= mem[ram_idx_s];
    end
  end

  // Response path, LED register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_r     <= 1'b0;
      bus_error_r <= 1'b0;
      leds_r      <= 8'd0;
      sel_ram_r   <= 1'b0;
      aux_data_r  <= 32'd0;
    end else begin
      ready_r <= access_s;
      if (access_s) begin
        sel_ram_r <= rd_ok_s && ram_hit_s;
        if (rd_ok_s && led_hit_s) begin
          aux_data_r <= {24'd0, leds_r};
        end else if (rd_ok_s && timer_hit_s) begin
          aux_data_r <= timer_count_s;
        end else begin
          aux_data_r <= 32'd0;
        end
        if (err_s) begin
          bus_error_r <= 1'b1;
        end
        if (wr_ok_s && led_hit_s) begin
          leds_r <= wdata_r[7:0];
        end
      end
    end
  end

  assign read_data = ready_r ? (sel_ram_r ? ram_q_r : aux_data_r) : 32'd0;
  assign ready     = ready_r;
  assign bus_error = bus_error_r;
  assign leds      = leds_r;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: driver queues expected responses, monitor checks each ready pulse.
module tb_mmio_responder;

  localparam logic [31:0] LED_A   = 32'h8000_0000;
  localparam logic [31:0] TIMER_A = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic        bus_error;
  logic [7:0]  leds;

  mmio_responder #(
    .CLOCK_FREQ       (4000),
    .DATA_MEMORY_SIZE (4096),
    .MEMORY_FILE      (""),
    .LED_ADDRESS      (LED_A),
    .TIMER_ADDRESS    (TIMER_A)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memory_read  (memory_read),
    .memory_write (memory_write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .bus_error    (bus_error),
    .leds         (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   ready_count = 0;
  int   edges = 0;
  logic err_model = 1'b0;
  logic prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reset-high clock edges seen so far; mirrors the prescaler phase after a reset.
  always @(posedge clk) begin
    if (!reset) edges = 0;
    else        edges = edges + 1;
  end

  // Monitor: every ready pulse consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      ready_count++;
      check("ready_one_cycle", {31'd0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ready: got ready=1 data=%h, expected no response", read_data);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_data"}, read_data, e.data);
        check({e.name, "_bus_error"}, {31'd0, bus_error}, {31'd0, e.err});
      end
    end else begin
      check("read_data_idle_zero", read_data, 32'd0);
    end
    prev_ready = ready;
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_data,
                       input logic is_err, input string name);
    exp_t e;
    int   n;
    @(negedge clk);
    memory_read  = rd;
    memory_write = wr;
    address      = addr;
    write_data   = wd;
    err_model    = err_model | is_err;
    e.data = exp_data;
    e.err  = err_model;
    e.name = name;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 8);
    check({name, "_latency"}, 32'(n), 32'd2);
    memory_read  = 1'b0;
    memory_write = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_data"}, read_data, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_bus_error"}, {31'd0, bus_error}, 32'd0);
    check({tag, "_leds"}, {24'd0, leds}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    err_model = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int rc;
    int guard;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // RAM round trips, including the last word and first out-of-range word.
    issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, "ram_store");
    issue(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "ram_load");
    issue(1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'd0, 1'b0, "ram_store2");
    issue(1'b0, 1'b1, 32'h0000_3FFC, 32'h0BAD_CAFE, 32'd0, 1'b0, "ram_store_last");
    issue(1'b1, 1'b0, 32'h0000_0014, 32'd0, 32'hCAFE_F00D, 1'b0, "ram_load2");
    issue(1'b1, 1'b0, 32'h0000_3FFC, 32'd0, 32'h0BAD_CAFE, 1'b0, "ram_load_last");

    // LED register.
    issue(1'b0, 1'b1, LED_A, 32'h1234_56A5, 32'd0, 1'b0, "led_store");
    @(negedge clk);
    check("led_value", {24'd0, leds}, 32'h0000_00A5);
    issue(1'b1, 1'b0, LED_A, 32'd0, 32'h0000_00A5, 1'b0, "led_load");

    // Error cases; none of them may disturb RAM or LEDs.
    issue(1'b1, 1'b0, 32'h0000_0002, 32'd0, 32'd0, 1'b1, "err_misaligned");
    issue(1'b0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "err_unmapped");
    issue(1'b1, 1'b0, 32'h0000_4000, 32'd0, 32'd0, 1'b1, "err_past_ram");
    issue(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'd0, 1'b1, "err_rw_ram");
    issue(1'b1, 1'b1, LED_A, 32'h0000_0000, 32'd0, 1'b1, "err_rw_led");
    issue(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "ram_after_err");
    issue(1'b1, 1'b0, LED_A, 32'd0, 32'h0000_00A5, 1'b0, "led_after_err");
    @(negedge clk);
    check("led_after_err_value", {24'd0, leds}, 32'h0000_00A5);

    // Reset arriving while a store is in flight.
    @(negedge clk);
    memory_write = 1'b1;
    address      = LED_A;
    write_data   = 32'h0000_005A;
    @(posedge clk);
    #1;
    memory_write = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    err_model = 1'b0;
    rc        = ready_count;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    check("midreset_no_ready", 32'(ready_count), 32'(rc));
    reset = 1'b1;
    issue(1'b1, 1'b0, LED_A, 32'd0, 32'd0, 1'b0, "led_after_reset");
    issue(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "ram_kept_over_reset");

`ifdef MMIO_TIMER_EN
    // Timer: 4 clk per ms with CLOCK_FREQ=4000.
    pulse_reset();
    guard = 0;
    while (edges != 38 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    issue(1'b1, 1'b0, TIMER_A, 32'd0, 32'd10, 1'b0, "timer_10ms");
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((edges % 4) != 1 && guard < 20);
    issue(1'b0, 1'b1, TIMER_A, 32'h1234_5678, 32'd0, 1'b0, "timer_clear_on_tick");
    issue(1'b1, 1'b0, TIMER_A, 32'd0, 32'd0, 1'b0, "timer_after_clear");

    pulse_reset();
    guard = 0;
    while (edges != 4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    force dut.u_timer.count_r = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_timer.count_r;
    issue(1'b1, 1'b0, TIMER_A, 32'd0, 32'hFFFF_FFFF, 1'b0, "timer_max");
    issue(1'b1, 1'b0, TIMER_A, 32'd0, 32'd0, 1'b0, "timer_wrap");
`else
    guard = 0;
    pulse_reset();
    issue(1'b1, 1'b0, TIMER_A, 32'd0, 32'd0, 1'b1, "timer_absent");
    issue(1'b0, 1'b1, TIMER_A, 32'h0000_0001, 32'd0, 1'b1, "timer_absent_store");
`endif

    repeat (3) @(negedge clk);
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
